// File: rtl/instr_byte_assembler_pkg.sv
// Shared core definitions: reset instruction and byte-lane index type.
package instr_byte_assembler_pkg;

    // RV32I canonical NOP: addi x0, x0, 0
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    // Index of a byte lane within a 32-bit instruction word
    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE = 2'd3;

endpackage

// File: rtl/instr_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit instruction words with a
// one-deep output register and valid/ready handshakes on both sides.
module instr_byte_assembler
    import instr_byte_assembler_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = RV32_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        sync,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  byte_cnt
);

    byte_idx_t   cnt_q;
    logic [23:0] asm_q;
    logic [31:0] instr_q;
    logic        valid_q;

    logic        accept;
    logic        word_done;

    // Only the completing byte needs a free output slot; earlier lanes can
    // fill while the previous word is still waiting to be consumed.
    always_comb begin
        byte_ready = !sync && !rst &&
                     (cnt_q != LAST_BYTE || !valid_q || instr_ready);
        accept     = byte_valid && byte_ready;
        word_done  = accept && (cnt_q == LAST_BYTE);
    end

    // Byte counter and assembly lanes; sync restarts the word from lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (sync) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    asm_q[7:0]   <= byte_in;
                2'd1:    asm_q[15:8]  <= byte_in;
                2'd2:    asm_q[23:16] <= byte_in;
                default: asm_q        <= asm_q;
            endcase
        end
    end

    // Output word register: a completing word wins over a consume so a
    // back-to-back stream keeps instr_valid high without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= RESET_INSTR;
            valid_q <= 1'b0;
        end else if (word_done) begin
            instr_q <= {byte_in, asm_q};
            valid_q <= 1'b1;
        end else if (instr_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_byte_assembler.sv
// Directed and randomized stimulus against a queue-based reference model.
module tb_instr_byte_assembler;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        sync;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  byte_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes accepted since the last sync/reset, plus the
    // currently presented word.
    logic [7:0]  partial[$];
    logic [31:0] m_instr;
    bit          m_valid;

    instr_byte_assembler dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .sync        (sync),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check byte_ready, advance model and DUT,
    // then check the registered outputs.
    task automatic step(input bit r, input bit s, input bit bv,
                        input logic [7:0] b, input bit ir);
        bit exp_ready;
        bit acc;
        bit delivered;
        rst = r; sync = s; byte_valid = bv; byte_in = b; instr_ready = ir;
        #1;
        exp_ready = !r && !s && (partial.size() != 3 || !m_valid || ir);
        check("byte_ready", {31'd0, byte_ready}, {31'd0, exp_ready});
        acc = bv && exp_ready;
        @(posedge clk);
        delivered = 1'b0;
        if (r) begin
            partial.delete();
            m_valid = 1'b0;
            m_instr = 32'h0000_0013;
        end else begin
            if (s) begin
                partial.delete();
            end else if (acc) begin
                partial.push_back(b);
                if (partial.size() == 4) begin
                    m_instr = {partial[3], partial[2], partial[1], partial[0]};
                    partial.delete();
                    m_valid = 1'b1;
                    delivered = 1'b1;
                end
            end
            if (ir && m_valid && !delivered) m_valid = 1'b0;
        end
        #1;
        check("instr", instr, m_instr);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check("byte_cnt", {30'd0, byte_cnt}, partial.size());
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit ir);
        step(1'b0, 1'b0, 1'b1, b, ir);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1; sync = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; instr_ready = 1'b0;
        m_instr = 32'h0000_0013;
        m_valid = 1'b0;

        // Reset release with no stimulus
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_cnt", {30'd0, byte_cnt}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd1);

        // Fill, then pre-load three bytes of the next word while it waits
        send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b0);
        check("w1_instr", instr, 32'h0010_0093);
        check("w1_valid", {31'd0, instr_valid}, 32'd1);
        send(8'h13, 1'b0); send(8'h01, 1'b0);
        check("pre_cnt2", {30'd0, byte_cnt}, 32'd2);
        send(8'h20, 1'b0);
        send(8'h00, 1'b0);
        check("stall_cnt", {30'd0, byte_cnt}, 32'd3);
        check("stall_instr", instr, 32'h0010_0093);
        // 4th byte completes on the consuming edge, valid stays high
        send(8'h00, 1'b1);
        check("repl_instr", instr, 32'h0020_0113);
        check("repl_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("drain_valid", {31'd0, instr_valid}, 32'd0);

        // Continuous stream with the consumer always ready
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        send(8'h93, 1'b1); send(8'h00, 1'b1); send(8'h10, 1'b1); send(8'h00, 1'b1);
        check("s1_instr", instr, 32'h0010_0093);
        send(8'h13, 1'b1); send(8'h01, 1'b1); send(8'h20, 1'b1);
        check("s_mid_valid", {31'd0, instr_valid}, 32'd0);
        send(8'h00, 1'b1);
        check("s2_instr", instr, 32'h0020_0113);
        check("s2_valid", {31'd0, instr_valid}, 32'd1);

        // Sync discards a partial word and drops a same-cycle byte
        send(8'hAA, 1'b1); send(8'hBB, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
        check("sync_cnt", {30'd0, byte_cnt}, 32'd0);
        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        check("sync_word", instr, 32'h0000_0013);
        check("sync_valid", {31'd0, instr_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-word
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
        check("midrst_instr", instr, 32'h0000_0013);
        send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);
        check("midrst_word", instr, 32'h0D0C_0B0A);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
